ro_seq_mux: RTL and testbench



---
 rtl/ro_pkg.sv | 22 ++
 rtl/ro_seq_mux_if.sv | 29 ++
 rtl/ro_slot_gray_cnt.sv | 40 ++++
 rtl/ro_seq_mux.sv | 54 +++++
 tb/tb_ro_seq_mux.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ro_pkg.sv
// ro_pkg: shared constants and helper functions for the sequential readout mux.
package ro_pkg;
    localparam int N_CH_DEF  = 8;
    localparam int W_DEF     = 2;
    localparam int CNT_W_DEF = 19;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Priority encoder: index of the lowest 0 bit among the low n bits, n-1 if all ones.
    function automatic int lowest_zero(input logic [63:0] v, input int n);
        int r;
        r = n - 1;
        for (int i = 63; i >= 0; i--)
            if (i < n && !v[i]) r = i;
        return r;
    endfunction
endpackage

// File: rtl/ro_seq_mux_if.sv
// ro_seq_mux_if: control, channel data and readout bus of the sequential readout mux.
interface ro_seq_mux_if
    import ro_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int CH_W  = clog2(N_CH)
);
    logic              en;
    logic              sparse;
    logic [N_CH-1:0]   ch_mask;
    logic [N_CH*W-1:0] in_data;
    logic [W-1:0]      out_data;
    logic [CH_W-1:0]   out_ch;
    logic              out_valid;
    logic              frame;
    logic [CNT_W-1:0]  gray;

    modport master (
        output en, sparse, ch_mask, in_data,
        input  out_data, out_ch, out_valid, frame, gray
    );

    modport slave (
        input  en, sparse, ch_mask, in_data,
        output out_data, out_ch, out_valid, frame, gray
    );
endinterface

// File: rtl/ro_slot_gray_cnt.sv
// ro_slot_gray_cnt: binary/gray slot counter reporting which gray bit toggles on the next increment.
module ro_slot_gray_cnt
    import ro_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int CH_W  = clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] gray,
    output logic [CH_W-1:0]  k,
    output logic             k_valid,
    output logic             wrap
);
    logic [CNT_W-1:0] b;
    logic [CNT_W-1:0] b_nxt;
    int               kk;

    assign b_nxt = b + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            b    <= '0;
            gray <= '0;
        end else if (en) begin
            b    <= b_nxt;
            gray <= b_nxt ^ (b_nxt >> 1);
        end
    end

    // k is only meaningful as a channel index when k_valid is set.
    always_comb begin
        kk      = lowest_zero(64'(b), CNT_W);
        k       = CH_W'(kk);
        k_valid = kk < N_CH;
        wrap    = &b;
    end
endmodule

// File: rtl/ro_seq_mux.sv
// ro_seq_mux: time-multiplexed registered readout of N_CH cores on octave-spaced gray slots.
module ro_seq_mux
    import ro_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int CH_W  = clog2(N_CH)
) (
    input logic          clk_master,
    input logic          reset,
    ro_seq_mux_if.slave  bus
);
    logic [CH_W-1:0] k;
    logic            k_valid;
    logic            wrap;
    logic [W-1:0]    d;
    logic            hit;
    logic [W-1:0]    last [N_CH];

    ro_slot_gray_cnt #(.N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W)) u_cnt (
        .clk     (clk_master),
        .rst     (reset),
        .en      (bus.en),
        .gray    (bus.gray),
        .k       (k),
        .k_valid (k_valid),
        .wrap    (wrap)
    );

    // Idle slots (k beyond the last channel) never hit, so k is only dereferenced when valid.
    always_comb begin
        d   = k_valid ? bus.in_data[k*W +: W] : '0;
        hit = k_valid && bus.ch_mask[k] && (!bus.sparse || d != last[k]);
    end

    always_ff @(posedge clk_master) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.frame     <= 1'b0;
            for (int i = 0; i < N_CH; i++) last[i] <= '0;
        end else begin
            bus.out_valid <= bus.en && hit;
            bus.frame     <= bus.en && wrap;
            if (bus.en && hit) begin
                bus.out_data <= d;
                bus.out_ch   <= k;
                last[k]      <= d;
            end
        end
    end
endmodule

// File: tb/tb_ro_seq_mux.sv
// tb_ro_seq_mux: randomized self-checking bench for ro_seq_mux against a slot-level reference model.
module tb_ro_seq_mux;
    localparam int N_CH  = 4;
    localparam int W     = 2;
    localparam int CNT_W = 5;
    localparam int CH_W  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int         mb;
    logic [1:0] mlast [N_CH];
    logic       ev, ef;
    logic [1:0] ech, ed;
    logic [4:0] eg;

    always #5 clk = ~clk;

    ro_seq_mux_if #(.N_CH(N_CH), .W(W), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

    ro_seq_mux #(.N_CH(N_CH), .W(W), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk_master (clk),
        .reset      (rst),
        .bus        (bus)
    );

    // Reference: channel k is served when the count's trailing-ones run has length k.
    task automatic tick();
        int         k;
        int         x;
        logic [1:0] dv;
        logic       hit;
        @(posedge clk);
        if (rst) begin
            mb = 0;
            for (int i = 0; i < N_CH; i++) mlast[i] = '0;
            ev = 0; ef = 0; ech = 0; ed = 0;
        end else if (!bus.en) begin
            ev = 0; ef = 0;
        end else begin
            k = 0;
            x = mb;
            while (x % 2 == 1 && k < CNT_W - 1) begin
                x = x / 2;
                k++;
            end
            hit = 0;
            dv  = '0;
            if (k < N_CH) begin
                dv  = bus.in_data[2*k +: 2];
                hit = bus.ch_mask[k] && (!bus.sparse || dv != mlast[k]);
            end
            ev = hit;
            if (hit) begin
                ech = 2'(k);
                ed  = dv;
                mlast[k] = dv;
            end
            ef = (mb == (1 << CNT_W) - 1);
            mb = (mb + 1) % (1 << CNT_W);
        end
        eg = 5'(mb ^ (mb >> 1));
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        bus.en = 1'($urandom);
        bus.sparse = 0;
        bus.ch_mask = 4'hF;
        bus.in_data = 8'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray} !== 11'd0) begin
                errors++;
                $display("FAIL reset cyc%0d got v=%b ch=%0d d=%0d f=%b g=%0d want all 0", i,
                         bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray);
            end
        end
    endtask

    task automatic test_full_rate();
        int   q[$];
        int   seq[8] = '{0, 1, 0, 2, 0, 1, 0, 3};
        int   gseq[4] = '{1, 3, 2, 6};
        int   last_t[N_CH];
        rst = 1;
        tick();
        rst = 0;
        bus.en = 1;
        bus.ch_mask = 4'hF;
        bus.sparse = 0;
        bus.in_data = 8'($urandom);
        for (int c = 0; c < N_CH; c++) last_t[c] = -1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray} !== {ev, ech, ed, ef, eg}) begin
                errors++;
                $display("FAIL full_rate t%0d got v=%b ch=%0d d=%0d f=%b g=%0d want v=%b ch=%0d d=%0d f=%b g=%0d",
                         i, bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray, ev, ech, ed, ef, eg);
            end
            if (i <= 4) begin
                checks++;
                if (int'(bus.gray) != gseq[i-1]) begin
                    errors++;
                    $display("FAIL gray_seq t%0d got %0d want %0d", i, bus.gray, gseq[i-1]);
                end
            end
            if (i == 16 || i == 32) begin
                checks++;
                if (bus.out_valid !== 1'b0 || bus.frame !== (i == 32)) begin
                    errors++;
                    $display("FAIL idle_slot t%0d got v=%b f=%b want v=0 f=%b", i, bus.out_valid, bus.frame, i == 32);
                end
            end
            if (bus.out_valid) begin
                q.push_back(int'(bus.out_ch));
                if (last_t[bus.out_ch] >= 0) begin
                    checks++;
                    if (i - last_t[bus.out_ch] != (2 << bus.out_ch)) begin
                        errors++;
                        $display("FAIL period ch%0d got %0d want %0d", bus.out_ch, i - last_t[bus.out_ch], 2 << bus.out_ch);
                    end
                end
                last_t[bus.out_ch] = i;
            end
        end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (j >= q.size() || q[j] != seq[j]) begin
                errors++;
                $display("FAIL ch_seq idx%0d got %0d want %0d", j, (j < q.size()) ? q[j] : -1, seq[j]);
            end
        end
    endtask

    task automatic test_mask();
        bus.ch_mask = 4'b1010;
        for (int i = 0; i < 48; i++) begin
            bus.in_data = 8'($urandom);
            tick();
            checks++;
            if ({bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray} !== {ev, ech, ed, ef, eg} ||
                (bus.out_valid && !bus.out_ch[0])) begin
                errors++;
                $display("FAIL mask t%0d got v=%b ch=%0d d=%0d f=%b g=%0d want v=%b ch=%0d d=%0d f=%b g=%0d",
                         i, bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray, ev, ech, ed, ef, eg);
            end
        end
    endtask

    task automatic test_sparse();
        int cnt[N_CH];
        int c2 = 0;
        rst = 1;
        tick();
        rst = 0;
        bus.en = 1;
        bus.sparse = 1;
        bus.ch_mask = 4'hF;
        bus.in_data = {2'd0, 2'd3, 2'd2, 2'd1};
        for (int c = 0; c < N_CH; c++) cnt[c] = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray} !== {ev, ech, ed, ef, eg}) begin
                errors++;
                $display("FAIL sparse t%0d got v=%b ch=%0d d=%0d want v=%b ch=%0d d=%0d", i,
                         bus.out_valid, bus.out_ch, bus.out_data, ev, ech, ed);
            end
            if (bus.out_valid) cnt[bus.out_ch]++;
        end
        for (int c = 0; c < N_CH; c++) begin
            checks++;
            if (cnt[c] != ((c == 3) ? 0 : 1)) begin
                errors++;
                $display("FAIL sparse_count ch%0d got %0d want %0d", c, cnt[c], (c == 3) ? 0 : 1);
            end
        end
        bus.in_data[5:4] = 2'b01;
        for (int i = 0; i < 24; i++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray} !== {ev, ech, ed, ef, eg}) begin
                errors++;
                $display("FAIL sparse_chg t%0d got v=%b ch=%0d d=%0d want v=%b ch=%0d d=%0d", i,
                         bus.out_valid, bus.out_ch, bus.out_data, ev, ech, ed);
            end
            if (bus.out_valid) begin
                checks++;
                if (bus.out_ch !== 2'd2 || bus.out_data !== 2'b01) begin
                    errors++;
                    $display("FAIL sparse_chg_ev got ch=%0d d=%0d want ch=2 d=1", bus.out_ch, bus.out_data);
                end
                c2++;
            end
        end
        checks++;
        if (c2 != 1) begin
            errors++;
            $display("FAIL sparse_chg_count got %0d want 1", c2);
        end
    endtask

    task automatic test_pause();
        logic [4:0] g0;
        logic [1:0] d0;
        bus.sparse = 0;
        bus.ch_mask = 4'hF;
        for (int i = 0; i < 7; i++) begin
            bus.in_data = 8'($urandom);
            tick();
        end
        g0 = bus.gray;
        d0 = bus.out_data;
        bus.en = 0;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 8'($urandom);
            tick();
            checks++;
            if (bus.gray !== g0 || bus.out_valid !== 1'b0 || bus.out_data !== d0 || bus.frame !== 1'b0) begin
                errors++;
                $display("FAIL pause t%0d got g=%0d v=%b d=%0d f=%b want g=%0d v=0 d=%0d f=0", i,
                         bus.gray, bus.out_valid, bus.out_data, bus.frame, g0, d0);
            end
        end
        bus.en = 1;
        for (int i = 0; i < 20; i++) begin
            bus.in_data = 8'($urandom);
            tick();
            checks++;
            if ({bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray} !== {ev, ech, ed, ef, eg}) begin
                errors++;
                $display("FAIL resume t%0d got v=%b ch=%0d d=%0d f=%b g=%0d want v=%b ch=%0d d=%0d f=%b g=%0d",
                         i, bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray, ev, ech, ed, ef, eg);
            end
        end
    endtask

    task automatic test_mid_reset();
        int cnt[N_CH];
        rst = 1;
        tick();
        rst = 0;
        bus.en = 1;
        bus.sparse = 1;
        bus.ch_mask = 4'hF;
        bus.in_data = {2'd2, 2'd3, 2'd1, 2'd2};
        for (int i = 0; i < 13; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if (bus.gray !== 5'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got g=%0d v=%b want g=0 v=0", bus.gray, bus.out_valid);
        end
        for (int c = 0; c < N_CH; c++) cnt[c] = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray} !== {ev, ech, ed, ef, eg}) begin
                errors++;
                $display("FAIL post_reset t%0d got v=%b ch=%0d d=%0d g=%0d want v=%b ch=%0d d=%0d g=%0d", i,
                         bus.out_valid, bus.out_ch, bus.out_data, bus.gray, ev, ech, ed, eg);
            end
            if (bus.out_valid) cnt[bus.out_ch]++;
        end
        for (int c = 0; c < N_CH; c++) begin
            checks++;
            if (cnt[c] != 1) begin
                errors++;
                $display("FAIL reemit ch%0d got %0d want 1", c, cnt[c]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.en = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 15) == 0) bus.sparse = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bus.ch_mask = 4'($urandom);
            if ($urandom_range(0, 3) == 0) bus.in_data = 8'($urandom);
            tick();
            checks++;
            if ({bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray} !== {ev, ech, ed, ef, eg}) begin
                errors++;
                $display("FAIL random t%0d got v=%b ch=%0d d=%0d f=%b g=%0d want v=%b ch=%0d d=%0d f=%b g=%0d",
                         i, bus.out_valid, bus.out_ch, bus.out_data, bus.frame, bus.gray, ev, ech, ed, ef, eg);
            end
        end
        rst = 0;
    endtask

    initial begin
        bus.en = 0;
        bus.sparse = 0;
        bus.ch_mask = '0;
        bus.in_data = '0;
        test_reset();
        test_full_rate();
        test_mask();
        test_sparse();
        test_pause();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
